// File: rtl/mu0_pkg.sv
// Shared constants for the MU0 control unit: opcodes, ALU function codes,
// FSM state encodings and the default instruction-counter width.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] FS_Y   = 2'b00;
  localparam logic [1:0] FS_ADD = 2'b01;
  localparam logic [1:0] FS_INC = 2'b10;
  localparam logic [1:0] FS_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/mu0_decode.sv
// EXEC-state instruction decoder. Purely combinational: produces the control
// word for the current opcode plus "done" (instruction completes this cycle)
// and "stop" (instruction is STP).
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Mem_Ready,
  output logic       x_sel_o,
  output logic       y_sel_o,
  output logic       addr_sel_o,
  output logic [1:0] alu_fs_o,
  output logic       pc_en_o,
  output logic       acc_en_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic       done_o,
  output logic       stop_o
);

  // Decode the opcode; memory opcodes gate their enable and completion on Mem_Ready.
  always_comb begin
    x_sel_o    = 1'b0;
    y_sel_o    = 1'b0;
    addr_sel_o = 1'b0;
    alu_fs_o   = FS_Y;
    pc_en_o    = 1'b0;
    acc_en_o   = 1'b0;
    rd_o       = 1'b0;
    wr_o       = 1'b0;
    done_o     = 1'b1;
    stop_o     = 1'b0;
    case (F)
      OP_LDA: begin
        addr_sel_o = 1'b1;
        rd_o       = 1'b1;
        alu_fs_o   = FS_Y;
        acc_en_o   = Mem_Ready;
        done_o     = Mem_Ready;
      end
      OP_STA: begin
        addr_sel_o = 1'b1;
        wr_o       = 1'b1;
        done_o     = Mem_Ready;
      end
      OP_ADD, OP_SUB: begin
        addr_sel_o = 1'b1;
        rd_o       = 1'b1;
        alu_fs_o   = (F == OP_ADD) ? FS_ADD : FS_SUB;
        acc_en_o   = Mem_Ready;
        done_o     = Mem_Ready;
      end
      OP_JMP: begin
        y_sel_o = 1'b1;
        pc_en_o = 1'b1;
      end
      OP_JGE: begin
        y_sel_o = 1'b1;
        pc_en_o = ~N;
      end
      OP_JNE: begin
        y_sel_o = 1'b1;
        pc_en_o = ~Z;
      end
      OP_STP: begin
        stop_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute sequencer with Mem_Ready wait states,
// registered Halted flag and a saturating completed-instruction counter.
// Handshake: a memory access is held (strobe stays high, enables low) until
// the cycle Mem_Ready=1; that cycle both loads the target register and
// completes the access. Mem_Ready is don't-care when no strobe is high.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_Ready,
  output logic             X_sel,
  output logic             Y_sel,
  output logic             Addr_sel,
  output logic [1:0]       ALU_fs,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       d_x_sel, d_y_sel, d_addr_sel, d_pc_en, d_acc_en, d_rd, d_wr;
  logic       d_done, d_stop;
  logic [1:0] d_alu_fs;
  logic       exec_done;

  mu0_decode u_decode (
    .F          (F),
    .N          (N),
    .Z          (Z),
    .Mem_Ready  (Mem_Ready),
    .x_sel_o    (d_x_sel),
    .y_sel_o    (d_y_sel),
    .addr_sel_o (d_addr_sel),
    .alu_fs_o   (d_alu_fs),
    .pc_en_o    (d_pc_en),
    .acc_en_o   (d_acc_en),
    .rd_o       (d_rd),
    .wr_o       (d_wr),
    .done_o     (d_done),
    .stop_o     (d_stop)
  );

  assign exec_done = (state_q == S_EXEC) && d_done;

  // State, halted flag and counter registers with asynchronous reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_FETCH;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: FETCH waits for Mem_Ready, EXEC waits for completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = Mem_Ready ? S_EXEC : S_FETCH;
      S_EXEC:  if (d_done) state_d = d_stop ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    halted_d = (state_d == S_HALT);
    cnt_d    = cnt_q;
    if (exec_done && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Output logic: FETCH/HALT words here, EXEC word from the decoder; all
  // forced low while Reset is asserted so strobes drop asynchronously.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = FS_Y;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    Rd       = 1'b0;
    Wr       = 1'b0;
    if (Reset) begin
      case (state_q)
        S_FETCH: begin
          X_sel  = 1'b1;
          ALU_fs = FS_INC;
          Rd     = 1'b1;
          PC_En  = Mem_Ready;
          IR_En  = Mem_Ready;
        end
        S_EXEC: begin
          X_sel    = d_x_sel;
          Y_sel    = d_y_sel;
          Addr_sel = d_addr_sel;
          ALU_fs   = d_alu_fs;
          PC_En    = d_pc_en;
          Acc_En   = d_acc_en;
          Rd       = d_rd;
          Wr       = d_wr;
        end
        default: begin
        end
      endcase
    end
  end

  assign Halted      = halted_q;
  assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control. Each test task drives a table of
// cycles; the expected control word of each cycle is pushed to exp_q when
// driven and popped at the falling edge when the outputs are sampled.
// A second instance with CNT_W=4 shares the inputs to check saturation.
module tb_mu0_control;

  localparam time HALF = 40ns;

  // Word layout: {X_sel,Y_sel,Addr_sel,ALU_fs,PC_En,IR_En,Acc_En,Rd,Wr,Halted}
  localparam logic [10:0] W_ZERO   = 11'b0_0_0_00_0_0_0_0_0_0;
  localparam logic [10:0] W_HALT   = 11'b0_0_0_00_0_0_0_0_0_1;
  localparam logic [10:0] W_FETCH  = 11'b1_0_0_10_1_1_0_1_0_0;
  localparam logic [10:0] W_FSTALL = 11'b1_0_0_10_0_0_0_1_0_0;
  localparam logic [10:0] W_ADD    = 11'b0_0_1_01_0_0_1_1_0_0;
  localparam logic [10:0] W_SUB    = 11'b0_0_1_11_0_0_1_1_0_0;
  localparam logic [10:0] W_LDA    = 11'b0_0_1_00_0_0_1_1_0_0;
  localparam logic [10:0] W_LDAW   = 11'b0_0_1_00_0_0_0_1_0_0;
  localparam logic [10:0] W_STA    = 11'b0_0_1_00_0_0_0_0_1_0;
  localparam logic [10:0] W_JT     = 11'b0_1_0_00_1_0_0_0_0_0;
  localparam logic [10:0] W_JN     = 11'b0_1_0_00_0_0_0_0_0_0;

  typedef struct {
    logic        rst;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        mr;
    logic [10:0] word;
    logic        done;
  } step_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  F;
  logic        N, Z, Mem_Ready;
  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted;
  logic [1:0]  ALU_fs;
  logic [15:0] Instr_Count;

  logic        s_x, s_y, s_a, s_pc, s_ir, s_acc, s_rd, s_wr, s_h;
  logic [1:0]  s_fs;
  logic [3:0]  cnt4;

  logic [10:0] exp_q[$];
  logic [15:0] cnt16_m;
  logic [3:0]  cnt4_m;
  int          checks = 0;
  int          failures = 0;

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_fs(ALU_fs),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .Rd(Rd), .Wr(Wr),
    .Halted(Halted), .Instr_Count(Instr_Count)
  );

  mu0_control #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
    .X_sel(s_x), .Y_sel(s_y), .Addr_sel(s_a), .ALU_fs(s_fs),
    .PC_En(s_pc), .IR_En(s_ir), .Acc_En(s_acc), .Rd(s_rd), .Wr(s_wr),
    .Halted(s_h), .Instr_Count(cnt4)
  );

  // Clock
  always #HALF Clk = ~Clk;

  function automatic logic [10:0] obs();
    return {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En, Rd, Wr, Halted};
  endfunction

  function automatic step_t s(logic rst, logic [3:0] f, logic n, logic z,
                              logic mr, logic [10:0] word, logic done);
    step_t t;
    t.rst = rst; t.f = f; t.n = n; t.z = z; t.mr = mr; t.word = word; t.done = done;
    return t;
  endfunction

  // Driver: apply one cycle of inputs, push its expected word, wait to sample point.
  task automatic drive_step(input step_t t);
    Reset = t.rst; F = t.f; N = t.n; Z = t.z; Mem_Ready = t.mr;
    if (!t.rst) begin
      cnt16_m = '0;
      cnt4_m  = '0;
    end
    exp_q.push_back(t.word);
    @(negedge Clk);
  endtask

  // Advance to just after the next rising edge and update the counter models.
  task automatic next_edge(input step_t t);
    @(posedge Clk);
    #1;
    if (t.rst && t.done) begin
      if (cnt16_m != 16'hFFFF) cnt16_m = cnt16_m + 16'd1;
      if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 4'd1;
    end
  endtask

  task automatic test_reset();
    step_t tb[$];
    logic [10:0] e;
    tb.push_back(s(0, 4'h0, 0, 0, 1, W_ZERO, 0));
    tb.push_back(s(0, 4'h0, 0, 0, 1, W_ZERO, 0));
    tb.push_back(s(1, 4'h8, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h8, 0, 0, 1, W_ZERO, 1));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL reset[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_add_sub();
    step_t tb[$];
    logic [10:0] e;
    tb.push_back(s(1, 4'h2, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h2, 0, 0, 1, W_ADD, 1));
    tb.push_back(s(1, 4'h3, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h3, 0, 0, 1, W_SUB, 1));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL add_sub[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_lda_wait();
    step_t tb[$];
    logic [10:0] e;
    tb.push_back(s(1, 4'h0, 0, 0, 0, W_FSTALL, 0));
    tb.push_back(s(1, 4'h0, 0, 0, 1, W_FETCH, 0));
    for (int k = 0; k < 3; k++) tb.push_back(s(1, 4'h0, 0, 0, 0, W_LDAW, 0));
    tb.push_back(s(1, 4'h0, 0, 0, 1, W_LDA, 1));
    tb.push_back(s(1, 4'h8, 0, 0, 1, W_FETCH, 0));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL lda_wait[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_jumps();
    step_t tb[$];
    logic [10:0] e;
    // Starts in EXEC: the previous test ended after a FETCH of F=8.
    tb.push_back(s(1, 4'h8, 0, 0, 0, W_ZERO, 1));
    tb.push_back(s(1, 4'h5, 1, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h5, 1, 0, 1, W_JN, 1));
    tb.push_back(s(1, 4'h5, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h5, 0, 0, 1, W_JT, 1));
    tb.push_back(s(1, 4'h6, 0, 1, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h6, 0, 1, 1, W_JN, 1));
    tb.push_back(s(1, 4'h6, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h6, 0, 0, 0, W_JT, 1));
    tb.push_back(s(1, 4'h4, 1, 1, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h4, 1, 1, 1, W_JT, 1));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL jumps[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_back_to_back();
    step_t tb[$];
    logic [10:0] e;
    tb.push_back(s(1, 4'h1, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h1, 0, 0, 1, W_STA, 1));
    tb.push_back(s(1, 4'h2, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h2, 0, 0, 1, W_ADD, 1));
    tb.push_back(s(1, 4'hC, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'hC, 0, 0, 1, W_ZERO, 1));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL back_to_back[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_halt();
    step_t tb[$];
    logic [10:0] e;
    tb.push_back(s(1, 4'h7, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h7, 0, 0, 1, W_ZERO, 1));
    for (int k = 0; k < 10; k++)
      tb.push_back(s(1, 4'($urandom_range(0, 15)), 0, 0,
                     1'($urandom_range(0, 1)), W_HALT, 0));
    tb.push_back(s(0, 4'h8, 0, 0, 1, W_ZERO, 0));
    tb.push_back(s(1, 4'h8, 0, 0, 1, W_FETCH, 0));
    tb.push_back(s(1, 4'h8, 0, 0, 1, W_ZERO, 1));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m) begin
        failures++;
        $display("FAIL halt[%0d]: word=%b cnt=%0d required word=%b cnt=%0d",
                 i, obs(), Instr_Count, e, cnt16_m);
      end
      next_edge(tb[i]);
    end
  endtask

  task automatic test_async_reset();
    step_t f;
    logic [10:0] e;
    f = s(1, 4'h1, 0, 0, 1, W_FETCH, 0);
    drive_step(f);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_fetch: word=%b required %b", obs(), e);
    end
    next_edge(f);
    // EXEC of STA stalled on Mem_Ready=0: Wr is high until Reset drops.
    Mem_Ready = 1'b0;
    exp_q.push_back(W_STA);
    #29;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_sta_wr: word=%b required %b", obs(), e);
    end
    Reset = 1'b0;
    cnt16_m = '0;
    cnt4_m  = '0;
    exp_q.push_back(W_ZERO);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e || Wr !== 1'b0 || Instr_Count !== cnt16_m) begin
      failures++;
      $display("FAIL async_drop: word=%b wr=%b cnt=%0d required word=%b wr=0 cnt=0",
               obs(), Wr, Instr_Count, e);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    checks++;
    if (Instr_Count !== 16'd0 || Rd !== 1'b1 || Wr !== 1'b0) begin
      failures++;
      $display("FAIL async_restart: cnt=%0d rd=%b wr=%b required cnt=0 rd=1 wr=0",
               Instr_Count, Rd, Wr);
    end
  endtask

  task automatic test_saturate();
    step_t tb[$];
    logic [10:0] e;
    for (int k = 0; k < 20; k++) begin
      tb.push_back(s(1, 4'h8, 0, 0, 1, W_FETCH, 0));
      tb.push_back(s(1, 4'h8, 0, 0, 1, W_ZERO, 1));
    end
    tb.push_back(s(1, 4'h8, 0, 0, 0, W_FSTALL, 0));
    foreach (tb[i]) begin
      drive_step(tb[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e || Instr_Count !== cnt16_m || cnt4 !== cnt4_m) begin
        failures++;
        $display("FAIL saturate[%0d]: word=%b cnt=%0d cnt4=%0d required word=%b cnt=%0d cnt4=%0d",
                 i, obs(), Instr_Count, cnt4, e, cnt16_m, cnt4_m);
      end
      next_edge(tb[i]);
    end
    checks++;
    if (cnt4 !== 4'd15 || Instr_Count !== 16'd20) begin
      failures++;
      $display("FAIL saturate_final: cnt4=%0d cnt=%0d required cnt4=15 cnt=20",
               cnt4, Instr_Count);
    end
  endtask

  initial begin
    Reset = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; Mem_Ready = 1'b1;
    cnt16_m = '0;
    cnt4_m  = '0;
    @(posedge Clk);
    #1;
    test_reset();
    test_add_sub();
    test_lda_wait();
    test_jumps();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_saturate();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
